// File: rtl/uart_fifo_ctrl.sv
// Parametrised UART/AXI FIFO with drop/overwrite full policy, almost-full/empty thresholds,
// sticky overflow/underflow flags and a saturating lost-data counter.
module uart_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          OVERWRITE  = 1'b0,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pull_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  clr_flags_i,
  input  logic [ADDR_WIDTH:0]   af_level_i,
  input  logic [ADDR_WIDTH:0]   ae_level_i,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [CNT_WIDTH-1:0]  lost_cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LevelFull = (ADDR_WIDTH + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0]  lost_q, lost_d;
  logic                  empty, full, wr_en, rd_en, ovf_ev, unf_ev;

  always_comb begin
    empty  = (level_q == '0);
    full   = (level_q == LevelFull);
    ovf_ev = push_i & ~pull_i & full;
    unf_ev = pull_i & empty;
    // A full FIFO still accepts the write when a pull frees a slot or the oldest word is evicted.
    wr_en  = push_i & (~full | pull_i | OVERWRITE);
    rd_en  = (pull_i & ~empty) | (ovf_ev & OVERWRITE);

    wptr_d  = wptr_q + ADDR_WIDTH'(wr_en);
    rptr_d  = rptr_q + ADDR_WIDTH'(rd_en);
    level_d = level_q + (ADDR_WIDTH + 1)'(wr_en) - (ADDR_WIDTH + 1)'(rd_en);

    // Events in the clearing cycle win over the clear.
    if (clr_flags_i) begin
      overflow_d  = ovf_ev;
      underflow_d = unf_ev;
      lost_d      = ovf_ev ? CNT_WIDTH'(1) : '0;
    end else begin
      overflow_d  = overflow_q | ovf_ev;
      underflow_d = underflow_q | unf_ev;
      lost_d      = (ovf_ev && (lost_q != '1)) ? lost_q + CNT_WIDTH'(1) : lost_q;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      lost_q      <= '0;
    end else if (rst_i) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      lost_q      <= '0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      lost_q      <= lost_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem[wptr_q] <= data_i;
    end
  end

  always_comb begin
    data_o         = empty ? '0 : mem[rptr_q];
    level_o        = level_q;
    empty_o        = empty;
    full_o         = full;
    almost_full_o  = (level_q >= af_level_i);
    almost_empty_o = (level_q <= ae_level_i);
    overflow_o     = overflow_q;
    underflow_o    = underflow_q;
    lost_cnt_o     = lost_q;
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: one drop-policy and one overwrite-policy instance.
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       push [2];
  logic       pull [2];
  logic       clr  [2];
  logic       rst  [2];
  logic [7:0] din  [2];
  logic [7:0] dout [2];
  logic [4:0] af   [2];
  logic [4:0] ae   [2];
  logic [4:0] lvl  [2];
  logic       emp  [2];
  logic       ful  [2];
  logic       afo  [2];
  logic       aeo  [2];
  logic       ovf  [2];
  logic       unf  [2];
  logic [7:0] lost [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OVERWRITE(1'b0), .CNT_WIDTH(8)) u_drop (
    .clk_i(clk), .arst_i(arst), .rst_i(rst[0]), .push_i(push[0]), .data_i(din[0]),
    .pull_i(pull[0]), .data_o(dout[0]), .clr_flags_i(clr[0]), .af_level_i(af[0]),
    .ae_level_i(ae[0]), .level_o(lvl[0]), .empty_o(emp[0]), .full_o(ful[0]),
    .almost_full_o(afo[0]), .almost_empty_o(aeo[0]), .overflow_o(ovf[0]),
    .underflow_o(unf[0]), .lost_cnt_o(lost[0])
  );

  uart_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OVERWRITE(1'b1), .CNT_WIDTH(8)) u_ovwr (
    .clk_i(clk), .arst_i(arst), .rst_i(rst[1]), .push_i(push[1]), .data_i(din[1]),
    .pull_i(pull[1]), .data_o(dout[1]), .clr_flags_i(clr[1]), .af_level_i(af[1]),
    .ae_level_i(ae[1]), .level_o(lvl[1]), .empty_o(emp[1]), .full_o(ful[1]),
    .almost_full_o(afo[1]), .almost_empty_o(aeo[1]), .overflow_o(ovf[1]),
    .underflow_o(unf[1]), .lost_cnt_o(lost[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: data_o is sampled mid-cycle whenever the consumer is pulling.
  always @(negedge clk) begin
    if (pull[0]) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL drop_rd: pull with no expected word queued");
      end else begin
        logic [7:0] e0;
        e0 = q0.pop_front();
        if (dout[0] !== e0) begin
          errors++;
          $display("FAIL drop_rd: got %0h, expected %0h", dout[0], e0);
        end
      end
    end
    if (pull[1]) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL ovwr_rd: pull with no expected word queued");
      end else begin
        logic [7:0] e1;
        e1 = q1.pop_front();
        if (dout[1] !== e1) begin
          errors++;
          $display("FAIL ovwr_rd: got %0h, expected %0h", dout[1], e1);
        end
      end
    end
  end

  // One clock of stimulus on instance k; a pull queues its expected data_o.
  task automatic step(input int k, input logic ps, input logic [7:0] d, input logic pl,
                      input logic [7:0] ex);
    push[k] = ps;
    din[k]  = d;
    pull[k] = pl;
    if (pl) begin
      if (k == 0) q0.push_back(ex);
      else        q1.push_back(ex);
    end
    @(posedge clk);
    #1;
    push[k] = 1'b0;
    pull[k] = 1'b0;
    clr[k]  = 1'b0;
    rst[k]  = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push[k] = 1'b0; pull[k] = 1'b0; clr[k] = 1'b0; rst[k] = 1'b0;
      din[k] = 8'h00; af[k] = 5'd12; ae[k] = 5'd3;
    end
    #2;
    check("rst_level", lvl[0], 0);
    check("rst_empty", emp[0], 1);
    check("rst_full", ful[0], 0);
    check("rst_ae", aeo[0], 1);
    check("rst_af", afo[0], 0);
    check("rst_data", dout[0], 0);
    check("rst_flags", {ovf[0], unf[0], lost[0]}, 0);
    af[0] = 5'd0;
    #1 check("rst_af0", afo[0], 1);
    af[0] = 5'd12;
    #9 arst = 1'b0;
    @(posedge clk); #1;

    // Fill with 0x01..0x10 while watching the thresholds.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1'b1, 8'(i), 1'b0, 8'h00);
      check("fill_level", lvl[0], i);
      check("fill_af", afo[0], (i >= 12) ? 1 : 0);
      check("fill_ae", aeo[0], (i <= 3) ? 1 : 0);
    end
    check("fill_full", ful[0], 1);
    af[0] = 5'd17;
    #1 check("af17", afo[0], 0);
    af[0] = 5'd12;

    // Drop policy: 0xAA discarded.
    step(0, 1'b1, 8'hAA, 1'b0, 8'h00);
    check("drop_ovf", ovf[0], 1);
    check("drop_lost", lost[0], 1);
    check("drop_level", lvl[0], 16);
    clr[0] = 1'b1;
    step(0, 1'b0, 8'h00, 1'b0, 8'h00);
    check("clr_lost", lost[0], 0);
    check("clr_ovf", ovf[0], 0);

    // Push+pull on full: 0x01 out, 0x11 in, no overflow.
    step(0, 1'b1, 8'h11, 1'b1, 8'h01);
    check("pp_full_level", lvl[0], 16);
    check("pp_full_ovf", ovf[0], 0);
    for (int i = 2; i <= 17; i++) step(0, 1'b0, 8'h00, 1'b1, 8'(i));
    check("drain_empty", emp[0], 1);
    check("drain_data0", dout[0], 0);

    // Push+pull on empty: push accepted, pull flagged.
    step(0, 1'b1, 8'h55, 1'b1, 8'h00);
    check("pp_empty_level", lvl[0], 1);
    check("pp_empty_unf", unf[0], 1);
    step(0, 1'b0, 8'h00, 1'b1, 8'h55);

    // Steady push+pull at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'h20 + i), 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) step(0, 1'b1, 8'(8'h25 + i), 1'b1, 8'(8'h20 + i));
    check("wrap_level", lvl[0], 5);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b1, 8'(8'h48 + i));
    check("wrap_empty", emp[0], 1);

    // Saturating loss counter.
    for (int i = 0; i < 16; i++) step(0, 1'b1, 8'(i), 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) step(0, 1'b1, 8'hEE, 1'b0, 8'h00);
    check("sat_lost", lost[0], 255);
    check("sat_ovf", ovf[0], 1);
    clr[0] = 1'b1;
    step(0, 1'b0, 8'h00, 1'b0, 8'h00);
    check("clr_alone", lost[0], 0);
    clr[0] = 1'b1;
    step(0, 1'b1, 8'hEE, 1'b0, 8'h00);
    check("clr_drop_lost", lost[0], 1);
    check("clr_drop_ovf", ovf[0], 1);

    // Soft reset overrides a simultaneous push.
    rst[0] = 1'b1;
    step(0, 1'b1, 8'h77, 1'b0, 8'h00);
    check("srst_level", lvl[0], 0);
    check("srst_flags", {ovf[0], unf[0], lost[0]}, 0);
    check("srst_empty", emp[0], 1);

    // Overwrite policy instance.
    for (int i = 1; i <= 16; i++) step(1, 1'b1, 8'(i), 1'b0, 8'h00);
    step(1, 1'b1, 8'hAA, 1'b0, 8'h00);
    check("ow_data", dout[1], 8'h02);
    check("ow_lost", lost[1], 1);
    check("ow_ovf", ovf[1], 1);
    check("ow_level", lvl[1], 16);
    for (int i = 2; i <= 16; i++) step(1, 1'b0, 8'h00, 1'b1, 8'(i));
    step(1, 1'b0, 8'h00, 1'b1, 8'hAA);
    check("ow_empty", emp[1], 1);

    // Asynchronous reset mid-burst, no clock edge.
    step(0, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'h60 + i), 1'b0, 8'h00);
    check("pre_arst_unf", unf[0], 1);
    arst = 1'b1;
    #1;
    check("arst_level", lvl[0], 0);
    check("arst_empty", emp[0], 1);
    check("arst_data", dout[0], 0);
    check("arst_flags", {ovf[0], unf[0], lost[0]}, 0);
    check("arst_ae", aeo[0], 1);
    arst = 1'b0;
    @(posedge clk); #1;

    check("sb_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
